// File: rtl/vga_layer_engine.sv
// VGA timing plus scaled-bitmap and round-sprite compositor; hsync/vsync/RGB share a 2-pix_en output pipeline.
// Optional sprite collision flag under macro SPRITE_COLLIDE_EN (default build ties collide to 0).
module vga_layer_engine #(
    parameter int         H_ACT    = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_ACT    = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 29,
    parameter int         IMG_W    = 181,
    parameter int         IMG_H    = 134,
    parameter int         SCALE    = 3,
    parameter int         ORG_X    = 50,
    parameter int         ORG_Y    = 40,
    parameter int         ROM_AW   = 15,
    parameter int         NSPR     = 2,
    parameter int         RADIUS   = 15,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 pix_en,
    input  logic [NSPR*10-1:0]   spr_x,
    input  logic [NSPR*10-1:0]   spr_y,
    input  logic [NSPR*8-1:0]    spr_rgb,
    output logic [ROM_AW-1:0]    rom_addr,
    input  logic [7:0]           rom_data,
    output logic                 hsync,
    output logic                 vsync,
    output logic [2:0]           red,
    output logic [2:0]           green,
    output logic [1:0]           blue,
    output logic                 frame_start,
    output logic                 collide
);
    localparam logic [9:0] H_ACT_C  = 10'(H_ACT);
    localparam logic [9:0] HS0_C    = 10'(H_ACT + H_FP);
    localparam logic [9:0] HS1_C    = 10'(H_ACT + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST_C = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACT);
    localparam logic [9:0] VS0_C    = 10'(V_ACT + V_FP);
    localparam logic [9:0] VS1_C    = 10'(V_ACT + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST_C = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] WX0_C    = 10'(ORG_X);
    localparam logic [9:0] WX1_C    = 10'(ORG_X + IMG_W * SCALE);
    localparam logic [9:0] WY0_C    = 10'(ORG_Y);
    localparam logic [9:0] WY1_C    = 10'(ORG_Y + IMG_H * SCALE);
    localparam logic [ROM_AW-1:0] IMG_W_A = ROM_AW'(IMG_W);
    localparam logic [1:0] SUB_LAST = 2'(SCALE - 1);
    localparam logic signed [21:0] R2 = 22'(RADIUS * RADIUS);

    logic [9:0]          hc_q, vc_q;
    logic [ROM_AW-1:0]   col_q, row_base_q, rom_addr_q;
    logic [1:0]          hsub_q, vsub_q;
    logic [NSPR*10-1:0]  sx_q, sy_q, sx_cur, sy_cur;
    logic [NSPR*8-1:0]   sc_q, sc_cur;
    logic                act1_q, hs1_q, vs1_q, win1_q, sph1_q;
    logic [7:0]          spc1_q, rgb_q;
    logic                hsync_q, vsync_q, frame_start_q;

    logic h_last, v_last, frame_px, act, x_in, y_in, in_win, hs_n, vs_n;
    logic [NSPR-1:0] in_spr;
    logic            spr_hit;
    logic [7:0]      spr_col, rgb_d;

    assign h_last   = (hc_q == H_LAST_C);
    assign v_last   = (vc_q == V_LAST_C);
    assign frame_px = (hc_q == 10'd0) && (vc_q == 10'd0);
    assign act      = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
    assign hs_n     = !((hc_q >= HS0_C) && (hc_q < HS1_C));
    assign vs_n     = !((vc_q >= VS0_C) && (vc_q < VS1_C));
    assign x_in     = (hc_q >= WX0_C) && (hc_q < WX1_C);
    assign y_in     = (vc_q >= WY0_C) && (vc_q < WY1_C);
    assign in_win   = x_in && y_in;

    // The frame's first pixel already uses the freshly sampled sprite inputs.
    assign sx_cur = frame_px ? spr_x   : sx_q;
    assign sy_cur = frame_px ? spr_y   : sy_q;
    assign sc_cur = frame_px ? spr_rgb : sc_q;

    for (genvar gi = 0; gi < NSPR; gi++) begin : g_spr
        logic signed [10:0] dx, dy;
        logic signed [21:0] d2;
        assign dx = $signed({1'b0, hc_q}) - $signed({1'b0, sx_cur[gi*10 +: 10]});
        assign dy = $signed({1'b0, vc_q}) - $signed({1'b0, sy_cur[gi*10 +: 10]});
        assign d2 = 22'(dx) * 22'(dx) + 22'(dy) * 22'(dy);
        assign in_spr[gi] = act && (d2 < R2);
    end

    always_comb begin
        spr_hit = 1'b0;
        spr_col = 8'h00;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (in_spr[i]) begin
                spr_hit = 1'b1;
                spr_col = sc_cur[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rgb_d = 8'h00;
        if (act1_q) rgb_d = sph1_q ? spc1_q : (win1_q ? rom_data : BG_COLOR);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            hc_q <= '0; vc_q <= '0;
            col_q <= '0; hsub_q <= '0; row_base_q <= '0; vsub_q <= '0;
            rom_addr_q <= '0;
            sx_q <= '0; sy_q <= '0; sc_q <= '0;
            act1_q <= 1'b0; hs1_q <= 1'b1; vs1_q <= 1'b1; win1_q <= 1'b0;
            sph1_q <= 1'b0; spc1_q <= '0;
            hsync_q <= 1'b1; vsync_q <= 1'b1; rgb_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en && frame_px;
            if (pix_en) begin
                hc_q <= h_last ? '0 : hc_q + 1'b1;
                if (h_last) vc_q <= v_last ? '0 : vc_q + 1'b1;
                if (frame_px) begin
                    sx_q <= spr_x; sy_q <= spr_y; sc_q <= spr_rgb;
                end
                // Column/row walk by sub-pixel replication; no multiply needed.
                if (x_in) begin
                    if (hsub_q == SUB_LAST) begin
                        hsub_q <= '0;
                        col_q  <= col_q + 1'b1;
                    end else begin
                        hsub_q <= hsub_q + 1'b1;
                    end
                end else begin
                    hsub_q <= '0;
                    col_q  <= '0;
                end
                if (h_last) begin
                    if (y_in) begin
                        if (vsub_q == SUB_LAST) begin
                            vsub_q     <= '0;
                            row_base_q <= row_base_q + IMG_W_A;
                        end else begin
                            vsub_q <= vsub_q + 1'b1;
                        end
                    end else begin
                        vsub_q     <= '0;
                        row_base_q <= '0;
                    end
                end
                rom_addr_q <= in_win ? row_base_q + col_q : '0;
                act1_q  <= act;  hs1_q <= hs_n;  vs1_q <= vs_n;  win1_q <= in_win;
                sph1_q  <= spr_hit; spc1_q <= spr_col;
                hsync_q <= hs1_q; vsync_q <= vs1_q; rgb_q <= rgb_d;
            end
        end
    end

`ifdef SPRITE_COLLIDE_EN
    logic multi, seen, coll_acc_q, collide_q;
    always_comb begin
        multi = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < NSPR; i++) begin
            if (in_spr[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
    end
    // The flag shown during a frame reflects overlaps seen in the previous one.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            coll_acc_q <= 1'b0;
            collide_q  <= 1'b0;
        end else if (pix_en) begin
            if (frame_px) begin
                collide_q  <= coll_acc_q;
                coll_acc_q <= multi;
            end else begin
                coll_acc_q <= coll_acc_q | multi;
            end
        end
    end
    assign collide = collide_q;
`else
    assign collide = 1'b0;
`endif

    assign rom_addr    = rom_addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_layer_engine.sv
// Scoreboard bench for vga_layer_engine on a shrunken raster; expected pixels come from a direct coordinate model.
module tb_vga_layer_engine;
    localparam int H_ACT = 48, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACT = 30, V_FP = 2, V_SYNC = 2, V_BP = 4;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int IMG_W = 5, IMG_H = 4, SCALE = 3, ORG_X = 10, ORG_Y = 6, ROM_AW = 8;
    localparam int NSPR = 2, RADIUS = 4;
    localparam logic [7:0] BG = 8'h49;

    logic clk = 1'b0, clr_n = 1'b0, pix_en = 1'b0;
    logic [NSPR*10-1:0] spr_x, spr_y;
    logic [NSPR*8-1:0]  spr_rgb;
    logic [ROM_AW-1:0]  rom_addr;
    logic [7:0]         rom_data = 8'h00;
    logic hsync, vsync, frame_start, collide;
    logic [2:0] red, green;
    logic [1:0] blue;

    vga_layer_engine #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .ORG_X(ORG_X), .ORG_Y(ORG_Y),
        .ROM_AW(ROM_AW), .NSPR(NSPR), .RADIUS(RADIUS), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .clr_n(clr_n), .pix_en(pix_en),
        .spr_x(spr_x), .spr_y(spr_y), .spr_rgb(spr_rgb),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .collide(collide)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_addr[7:0];

    int n_cmp = 0, n_bad = 0;
    int mh, mv, frame;
    int lsx [NSPR], lsy [NSPR];
    logic [7:0] lsc [NSPR];
    logic acc, exp_coll;
    logic [9:0] q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_window(input int x, input int y);
        return x >= ORG_X && x < ORG_X + IMG_W * SCALE && y >= ORG_Y && y < ORG_Y + IMG_H * SCALE;
    endfunction

    function automatic int exp_addr(input int x, input int y);
        if (!in_window(x, y)) return 0;
        return ((y - ORG_Y) / SCALE) * IMG_W + (x - ORG_X) / SCALE;
    endfunction

    function automatic bit covers(input int i, input int x, input int y);
        int dx, dy;
        dx = x - lsx[i];
        dy = y - lsy[i];
        return (x < H_ACT) && (y < V_ACT) && (dx * dx + dy * dy < RADIUS * RADIUS);
    endfunction

    function automatic logic [9:0] exp_px(input int x, input int y);
        logic hs, vs;
        logic [7:0] c;
        hs = !(x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SYNC);
        vs = !(y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SYNC);
        c  = 8'h00;
        if (x < H_ACT && y < V_ACT) begin
            c = in_window(x, y) ? 8'(exp_addr(x, y)) : BG;
            for (int i = NSPR - 1; i >= 0; i--)
                if (covers(i, x, y)) c = lsc[i];
        end
        return {hs, vs, c};
    endfunction

    function automatic bit multi_hit(input int x, input int y);
        int n = 0;
        for (int i = 0; i < NSPR; i++) if (covers(i, x, y)) n++;
        return n >= 2;
    endfunction

    task automatic set_spr(input int x0, input int y0, input logic [7:0] c0,
                           input int x1, input int y1, input logic [7:0] c1);
        spr_x   = {10'(x1), 10'(x0)};
        spr_y   = {10'(y1), 10'(y0)};
        spr_rgb = {c1, c0};
    endtask

    task automatic step(input logic pe);
        logic fs_exp;
        int a_exp;
        fs_exp = 1'b0;
        a_exp  = 0;
        @(negedge clk);
        pix_en = pe;
        if (pe) begin
            if (mh == 0 && mv == 0) begin
                for (int i = 0; i < NSPR; i++) begin
                    lsx[i] = int'(spr_x[i*10 +: 10]);
                    lsy[i] = int'(spr_y[i*10 +: 10]);
                    lsc[i] = spr_rgb[i*8 +: 8];
                end
                fs_exp = 1'b1;
`ifdef SPRITE_COLLIDE_EN
                exp_coll = acc;
`endif
                acc = 1'b0;
            end
            q.push_back(exp_px(mh, mv));
            a_exp = exp_addr(mh, mv);
            acc = acc | multi_hit(mh, mv);
            if (mh == H_TOT - 1) begin
                mh = 0;
                if (mv == V_TOT - 1) begin
                    mv = 0;
                    frame++;
                end else mv++;
            end else mh++;
        end
        @(posedge clk);
        #1;
        check_val("frame_start", frame_start, fs_exp);
        if (pe) begin
            check_val("rom_addr", rom_addr, a_exp);
            check_val("collide", collide, exp_coll);
            if (q.size() >= 2) check_val("pixel", {hsync, vsync, red, green, blue}, q.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n  = 1'b0;
        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_sync", {hsync, vsync}, 2'b11);
        check_val("rst_rgb", {red, green, blue}, 8'h00);
        check_val("rst_fs", frame_start, 1'b0);
        check_val("rst_addr", rom_addr, 0);
        check_val("rst_coll", collide, 1'b0);
        @(negedge clk);
        clr_n  = 1'b1;
        pix_en = 1'b0;
        mh = 0; mv = 0; frame = 0;
        for (int i = 0; i < NSPR; i++) begin
            lsx[i] = 0; lsy[i] = 0; lsc[i] = 8'h00;
        end
        acc = 1'b0;
        exp_coll = 1'b0;
        q.delete();
        q.push_back(10'b11_0000_0000);
    endtask

    initial begin
        int k;
        logic pe;
        set_spr(0, 0, 8'hE0, 40, 20, 8'h1C);
        do_reset();
        for (int i = 0; i < 1200; i++) step(i % 4 == 3);
        do_reset();
        k = 0;
        while (!(frame == 3 && mv == 2)) begin
            if (k >= 40000) begin
                check_val("run_bound", frame, 3);
                break;
            end
            pe = (k % 4 == 3);
            if (pe && mh == 0 && frame == 0 && mv == 10) set_spr(12, 8, 8'hE0, 15, 8, 8'h1C);
            if (pe && mh == 0 && frame == 1 && mv == 20) set_spr(30, 25, 8'hE0, 38, 25, 8'h1C);
            step(pe);
            k++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_layer_engine.md
VGA_LAYER_ENGINE -- requirements
Module: vga_layer_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_ACT 640, active pixels; H_FP 16, front porch; H_SYNC 96, sync pulse; H_BP 48, back porch.
REQ-002 SHALL have parameters: V_ACT 480, active lines; V_FP 10, front porch; V_SYNC 2, sync pulse; V_BP 29, back porch.
REQ-003 SHALL have parameters: IMG_W 181, IMG_H 134, bitmap size; SCALE 3, integer replication factor (1..4); ORG_X 50, ORG_Y 40, bitmap origin in active coordinates; ROM_AW 15, ROM address width.
REQ-004 SHALL have parameters: NSPR 2, sprite count (1..8); RADIUS 15, sprite radius in pixels; BG_COLOR 8'h00, background RGB332.
REQ-005 SHALL have ports (name, direction, width, meaning): clk, in, 1, system clock; clr_n, in, 1, reset, synchronous, active-low.
REQ-006 SHALL have port pix_en, in, 1, pixel strobe (one clk in every 4); all timing advances only on clk edges with pix_en=1.
REQ-007 SHALL have ports spr_x, in, NSPR*10, packed sprite centre X (active coords); spr_y, in, NSPR*10, centre Y; spr_rgb, in, NSPR*8, sprite colour RGB332.
REQ-008 SHALL have ports rom_addr, out, ROM_AW, bitmap address; rom_data, in, 8, RGB332 data, valid one clk after rom_addr.
REQ-009 SHALL have ports hsync, out, 1; vsync, out, 1; red, out, 3; green, out, 3; blue, out, 2; frame_start, out, 1; collide, out, 1.

Function
REQ-010 SHALL count hc 0..H_TOT-1 (H_TOT=H_ACT+H_FP+H_SYNC+H_BP) and vc 0..V_TOT-1, hc wrapping advances vc, vc wrapping at V_TOT-1 to 0.
REQ-011 SHALL drive hsync/vsync low during their sync pulse regions, high otherwise; active region is hc<H_ACT and vc<V_ACT.
REQ-012 SHALL register outputs with a fixed 2-pix_en pipeline latency; hsync, vsync, and RGB SHALL be delayed identically so they stay aligned.
REQ-013 SHALL address the bitmap with incremental row/column counters plus SCALE sub-counters, no multiplier; each source pixel is replicated SCALE x SCALE.
REQ-014 SHALL have rom_addr = row*IMG_W+col inside window [ORG_X, ORG_X+IMG_W*SCALE) x [ORG_Y, ORG_Y+IMG_H*SCALE), and SHALL hold 0 outside it.
REQ-015 SHALL treat a pixel as inside sprite i when dx*dx+dy*dy < RADIUS*RADIUS, with dx, dy computed as signed 11-bit differences; there is no wrap-around aliasing at screen edges.
REQ-016 SHALL use colour priority: lowest-index covering sprite > bitmap > BG_COLOR; outside the active region RGB SHALL be 0.
REQ-017 SHALL sample spr_x/spr_y/spr_rgb only at the frame start pixel (hc=0, vc=0); mid-frame changes SHALL take effect the next frame, so sprites are tear-free.
REQ-018 SHALL pulse frame_start high for exactly one clk, on the pix_en edge where hc=0, vc=0.
REQ-019 SHALL hold all state on clk edges where pix_en=0, except the one-clk ROM read alignment.

Reset
REQ-020 SHALL, on a clk edge with clr_n=0, set hc=vc=0, clear all sub-counters and pipeline registers, set hsync=vsync=1, RGB=0, frame_start=0, collide=0, rom_addr=0, and clear latched sprite data to 0.
REQ-021 SHALL, on reset mid-frame, abandon the frame; the first frame_start SHALL occur on the first pix_en with clr_n=1.

Configuration
REQ-022 SHALL implement sprite collision detection only when macro SPRITE_COLLIDE_EN is defined.
REQ-023 SHALL, with SPRITE_COLLIDE_EN defined, set collide for one whole frame when any active pixel of the previous frame lay inside two or more sprites, updated at frame_start.
REQ-024 SHALL, without SPRITE_COLLIDE_EN, tie collide to 0 and contain no collision logic.

Verification
REQ-025 SHALL check reset timing: clr_n=0 for 3 clks, then pix_en every 4th clk -> hsync low for hc 656..751, vsync low for vc 490..491, frame period 800*521 pix_en.
REQ-026 SHALL check bitmap scaling: ROM model rom_data=addr[7:0], SCALE=3 -> active pixel (50,40)..(52,42) equals data of addr 0, pixel (53,40) of addr 1, pixel (50,43) of addr 181, pixel (593,40) BG_COLOR.
REQ-027 SHALL check sprite priority: spr0=(100,100,8'hE0), spr1=(105,100,8'h1C) -> pixel (103,100) red 7 green 0 blue 0; pixel (118,100) green 7.
REQ-028 SHALL check sprite clipping: spr0=(0,0) -> pixel (10,0) sprite colour, pixel (639,479) not; no sync disturbance.
REQ-029 SHALL check tear-free update: change spr_x at vc=200 -> current frame unchanged, new position from next frame_start.
REQ-030 SHALL check collision, with SPRITE_COLLIDE_EN defined: sprites 20 px apart -> collide=1 next frame; 40 px apart -> collide=0 next frame.
